mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit output channel between four requesters by sequencing the select of the existing 4-to-1 datapath multiplexer. Each requester presents data on its own input and raises a request. The arbiter grants one requester at a time for a bounded burst and drives the multiplexer select. Data moves downstream under a valid/ready handshake, and the granted requester receives a per-beat acknowledge.

---
 rtl/mux4_rr_arbiter_pkg.sv | 22 ++
 rtl/mux4_rr_arbiter_mux.sv | 24 ++
 rtl/mux4_rr_arbiter.sv | 90 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: state encodings, requester
// count, select width and the rotating-priority winner function.
package mux4_rr_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // First set request bit scanning ptr, ptr+1, ... mod 4; returns ptr if none.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    rr_pick = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// Existing 4-to-1 datapath multiplexer; M follows the input picked by S.
module mux_4to1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] M
);

  always_comb begin
    M = A;
    case (S)
      2'd0: M = A;
      2'd1: M = B;
      2'd2: M = C;
      2'd3: M = D;
      default: M = A;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sequencing the select of mux_4to1 so four requesters
// share one output channel in bounded bursts under valid/ready.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic             out_ready,
  output logic [WIDTH-1:0] M,
  output logic [1:0]       S,
  output logic             out_valid,
  output logic [3:0]       ack,
  output logic             busy
);

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             accept;

  // Reset masks the handshake so a beat in flight at reset is never acked.
  assign out_valid = ~rst & (state_q == ST_GRANT) & req[sel_q];
  assign accept    = out_valid & out_ready;
  assign ack       = accept ? (4'b0001 << sel_q) : 4'b0000;
  assign busy      = (state_q == ST_GRANT);
  assign S         = sel_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 4'b0000) begin
          sel_d   = rr_pick(req, ptr_q);
          cnt_d   = 4'd0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[sel_q]) begin
          state_d = ST_IDLE;
          ptr_d   = sel_q + 2'd1;
        end else if (accept) begin
          if (cnt_q == 4'(MAX_BURST - 1)) begin
            state_d = ST_IDLE;
            ptr_d   = sel_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  mux_4to1 #(.WIDTH(WIDTH)) u_mux (
    .A(A),
    .B(B),
    .C(C),
    .D(D),
    .S(sel_q),
    .M(M)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed cycle-by-cycle vectors for mux4_rr_arbiter plus a stalled-burst
// sequence; outputs are sampled on the falling edge.
module tb_mux4_rr_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] A, B, C, D;
  logic             out_ready;
  logic [WIDTH-1:0] M;
  logic [1:0]       S;
  logic             out_valid;
  logic [3:0]       ack;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [1:0] s;
    logic       valid;
    logic [3:0] ack;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  logic [WIDTH-1:0] dat [4];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .A(A), .B(B), .C(C), .D(D),
    .out_ready(out_ready), .M(M), .S(S),
    .out_valid(out_valid), .ack(ack), .busy(busy)
  );

  task automatic v(input logic r, input logic [3:0] rq, input logic rd,
                   input logic [1:0] s, input logic vl, input logic [3:0] ak,
                   input logic bz, input int n);
    vec_t e;
    e.rst = r; e.req = rq; e.rdy = rd; e.s = s; e.valid = vl; e.ack = ak; e.busy = bz;
    for (int k = 0; k < n; k++) vecs.push_back(e);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    A = 32'hABCDEFF1; B = 32'h76543210; C = 32'h11111111; D = 32'h22222222;
    dat[0] = A; dat[1] = B; dat[2] = C; dat[3] = D;

    //  rst req    rdy  S   vld ack     busy n
    v(1, 4'b1111, 1, 2'd0, 0, 4'b0000, 0, 3);   // reset held with all requests
    v(0, 4'b0010, 1, 2'd0, 0, 4'b0000, 0, 1);   // IDLE, B requests
    v(0, 4'b0010, 1, 2'd1, 1, 4'b0010, 1, 4);   // 4-beat burst to B
    v(0, 4'b0010, 1, 2'd1, 0, 4'b0000, 0, 1);   // bubble
    v(0, 4'b0010, 1, 2'd1, 1, 4'b0010, 1, 1);   // regrant B
    v(1, 4'b0010, 1, 2'd1, 0, 4'b0000, 1, 1);   // reset in GRANT: no ack
    v(0, 4'b1111, 1, 2'd0, 0, 4'b0000, 0, 1);   // rotation
    v(0, 4'b1111, 1, 2'd0, 1, 4'b0001, 1, 4);
    v(0, 4'b1111, 1, 2'd0, 0, 4'b0000, 0, 1);
    v(0, 4'b1111, 1, 2'd1, 1, 4'b0010, 1, 4);
    v(0, 4'b1111, 1, 2'd1, 0, 4'b0000, 0, 1);
    v(0, 4'b1111, 1, 2'd2, 1, 4'b0100, 1, 4);
    v(0, 4'b1111, 1, 2'd2, 0, 4'b0000, 0, 1);
    v(0, 4'b1111, 1, 2'd3, 1, 4'b1000, 1, 4);
    v(0, 4'b1111, 1, 2'd3, 0, 4'b0000, 0, 1);
    v(0, 4'b1111, 1, 2'd0, 1, 4'b0001, 1, 1);   // wrapped back to A
    v(1, 4'b1111, 1, 2'd0, 0, 4'b0000, 1, 1);
    v(0, 4'b0100, 1, 2'd0, 0, 4'b0000, 0, 1);   // grant C
    v(0, 4'b0100, 0, 2'd2, 1, 4'b0000, 1, 3);   // stall
    v(0, 4'b0100, 1, 2'd2, 1, 4'b0100, 1, 1);   // single beat
    v(0, 4'b0000, 1, 2'd2, 0, 4'b0000, 1, 1);   // C drops -> ptr=3
    v(0, 4'b0101, 1, 2'd2, 0, 4'b0000, 0, 1);   // wrap and skip: A wins
    v(0, 4'b0101, 1, 2'd0, 1, 4'b0001, 1, 4);
    v(0, 4'b0101, 1, 2'd0, 0, 4'b0000, 0, 1);   // ptr=1 -> C wins
    v(0, 4'b0101, 1, 2'd2, 1, 4'b0100, 1, 1);
    v(0, 4'b1000, 1, 2'd2, 0, 4'b0000, 1, 1);   // C drops -> ptr=3
    v(0, 4'b1000, 1, 2'd2, 0, 4'b0000, 0, 1);
    v(0, 4'b1000, 1, 2'd3, 1, 4'b1000, 1, 2);   // 2 beats to D
    v(1, 4'b1000, 1, 2'd3, 0, 4'b0000, 1, 1);   // reset mid-burst
    v(0, 4'b0000, 1, 2'd0, 0, 4'b0000, 0, 1);
    v(0, 4'b1010, 1, 2'd0, 0, 4'b0000, 0, 1);   // ptr=0 after reset -> B
    v(0, 4'b1010, 1, 2'd1, 1, 4'b0010, 1, 1);

    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; req = vecs[i].req; out_ready = vecs[i].rdy;
      @(negedge clk);
      chk("S",         i, 32'(S),         32'(vecs[i].s));
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].valid));
      chk("ack",       i, 32'(ack),       32'(vecs[i].ack));
      chk("busy",      i, 32'(busy),      32'(vecs[i].busy));
      chk("M",         i, M,              dat[vecs[i].s]);
      @(posedge clk); #1;
    end

    // Stalled burst to A: out_ready toggles; still exactly MAX_BURST acks.
    begin
      int  nack = 0;
      int  nbad = 0;
      logic seen = 1'b0;
      logic done = 1'b0;
      req = 4'b0001;
      for (int c = 0; c < 40 && !done; c++) begin
        out_ready = c[0];
        @(negedge clk);
        if (ack == 4'b0001) begin nack++; seen = 1'b1; end
        else if (ack != 4'b0000) nbad++;
        if (seen && !busy) done = 1'b1;
        @(posedge clk); #1;
      end
      chk("stall_burst_done", 0, 32'(done), 32'd1);
      chk("stall_burst_acks", 0, 32'(nack), 32'd4);
      chk("stall_burst_badack", 0, 32'(nbad), 32'd0);
      @(negedge clk);
      chk("stall_regrant_S", 0, 32'(S), 32'd0);
      chk("stall_regrant_busy", 0, 32'(busy), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
